// File: rtl/cpu_v2_pkg.sv
// cpu_v2_pkg: shared definitions for the cpu_v2 multi-cycle core.
//   - opcode_e : instruction opcodes (anything not listed decodes as NOP)
//   - state_e  : control FSM states
//   - instruction field positions/widths and the PC increment
package cpu_v2_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_STR  = 4'h3,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALTED
    } state_e;

    // Instruction word layout: op[31:28] rd[27:24] rs1[23:20] rs2[19:16] imm[15:0]
    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 20;
    localparam int RS2_LSB = 16;
    localparam int IMM_LSB = 0;
    localparam int FIELD_W = 4;
    localparam int IMM_W   = 16;

    localparam int PC_INC  = 4;

endpackage

// File: rtl/cpu_v2_regfile.sv
// cpu_v2_regfile: REG_COUNT x DATA_WIDTH register file.
//   clk, reset (async, active-low; clears every entry)
//   rs1_addr/rs1_data, rs2_addr/rs2_data : two combinational read ports
//   wr_en, wr_addr, wr_data              : one synchronous write port
// r0 always reads as zero and is never written.
module cpu_v2_regfile
    import cpu_v2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FIELD_W-1:0]    rs1_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [FIELD_W-1:0]    rs2_addr,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wr_en,
    input  logic [FIELD_W-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/cpu_v2.sv
// cpu_v2: multi-cycle core executing ADD, ADDI, SUB, STR and HALT.
//   clk, reset (async, active-low)
//   start/start_pc     : launch execution from IDLE or HALTED
//   imem_req/addr/ack/rdata : instruction fetch handshake (addr = PC)
//   dmem_req/addr/wdata/ack : store handshake
//   pc, busy, halted   : bring-up status
//   retired            : instruction retire counter, present only when
//                        CPU_V2_RETIRE_CNT_EN is defined
module cpu_v2
    import cpu_v2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_COUNT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic                  dmem_req,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  halted
`ifdef CPU_V2_RETIRE_CNT_EN
    ,
    output logic [31:0]           retired
`endif
);

    state_e                state;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] result;

    logic [FIELD_W-1:0]    f_op;
    logic [FIELD_W-1:0]    f_rd;
    logic [FIELD_W-1:0]    f_rs1;
    logic [FIELD_W-1:0]    f_rs2;
    logic signed [IMM_W-1:0] f_imm;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] addr_sum;
    logic                  is_nop;
    logic                  start_ok;

    assign f_op    = instr[OP_LSB  +: FIELD_W];
    assign f_rd    = instr[RD_LSB  +: FIELD_W];
    assign f_rs1   = instr[RS1_LSB +: FIELD_W];
    assign f_rs2   = instr[RS2_LSB +: FIELD_W];
    assign f_imm   = signed'(instr[IMM_LSB +: IMM_W]);
    // Size cast of a signed value sign-extends.
    assign imm_ext = DATA_WIDTH'(f_imm);

    assign is_nop  = !(f_op inside {OP_ADD, OP_ADDI, OP_SUB, OP_STR, OP_HALT});
    assign start_ok = start && ((state == S_IDLE) || (state == S_HALTED));

    assign imem_addr = pc;
    assign busy      = (state != S_IDLE) && (state != S_HALTED);
    assign halted    = (state == S_HALTED);

    cpu_v2_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (f_rs1),
        .rs1_data (rs1_data),
        .rs2_addr (f_rs2),
        .rs2_data (rs2_data),
        .wr_en    (state == S_WRITEBACK),
        .wr_addr  (f_rd),
        .wr_data  (result)
    );

    always_comb begin
        alu_out = op_a + op_b;
        case (f_op)
            OP_ADDI: alu_out = op_a + imm_ext;
            OP_SUB:  alu_out = op_a - op_b;
            default: alu_out = op_a + op_b;
        endcase
    end

    assign addr_sum = op_a + imm_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            instr      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc       <= start_pc;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // req is already high here, so ack is never taken while req is low.
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a  <= rs1_data;
                    op_b  <= rs2_data;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (f_op == OP_HALT) begin
                        state <= S_HALTED;
                    end else begin
                        pc <= pc + ADDR_WIDTH'(PC_INC);
                        if (f_op == OP_STR) begin
                            dmem_addr  <= ADDR_WIDTH'(addr_sum);
                            dmem_wdata <= op_b;
                            dmem_req   <= 1'b1;
                            state      <= S_MEMORY;
                        end else if (is_nop) begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            result <= alu_out;
                            state  <= S_WRITEBACK;
                        end
                    end
                end
                S_MEMORY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CPU_V2_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (start_ok) begin
            retired <= '0;
        end else if ((state == S_WRITEBACK) ||
                     ((state == S_MEMORY) && dmem_ack) ||
                     ((state == S_EXECUTE) && is_nop)) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_v2.sv
module tb_cpu_v2;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_pc = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_req;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
`ifdef CPU_V2_RETIRE_CNT_EN
    logic [31:0]   retired;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [0:255];
    int          imem_delay = 0;
    int          imem_wait = 0;
    logic        dmem_hold = 1'b0;
    int          store_cnt = 0;
    logic [AW-1:0] st_addr [0:15];
    logic [DW-1:0] st_data [0:15];

    cpu_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_pc   (start_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
`ifdef CPU_V2_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    always #5 clk = ~clk;

    // Memory responders
    assign imem_rdata = imem[imem_addr[9:2]];
    assign imem_ack   = imem_req && (imem_wait >= imem_delay);
    assign dmem_ack   = dmem_req && !dmem_hold;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) imem_wait <= imem_wait + 1;
        else                       imem_wait <= 0;
        if (reset && dmem_req && dmem_ack && store_cnt < 16) begin
            st_addr[store_cnt] <= dmem_addr;
            st_data[store_cnt] <= dmem_wdata;
            store_cnt <= store_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] addr);
        start_pc = addr;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        check(tag, {63'd0, halted}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
        // Program 1 @0x100
        imem[64]  = 32'h1100_0005;  // ADDI r1,r0,5
        imem[65]  = 32'h1200_0007;  // ADDI r2,r0,7
        imem[66]  = 32'h0312_0000;  // ADD  r3,r1,r2
        imem[67]  = 32'h3003_0040;  // STR  r3,[r0+0x40]
        imem[68]  = 32'hF000_0000;  // HALT
        // Program 2 @0x200
        imem[128] = 32'h2412_0000;  // SUB  r4,r1,r2
        imem[129] = 32'h1500_FFFF;  // ADDI r5,r0,-1
        imem[130] = 32'h3004_0044;  // STR  r4,[r0+0x44]
        imem[131] = 32'h3005_0048;  // STR  r5,[r0+0x48]
        imem[132] = 32'h5000_0000;  // NOP
        imem[133] = 32'h1000_0009;  // ADDI r0,r0,9
        imem[134] = 32'h3000_0000;  // STR  r0,[r0+0]
        imem[135] = 32'hF000_0000;  // HALT
        // Program 3 @0x300
        imem[192] = 32'h0612_0000;  // ADD  r6,r1,r2
        imem[193] = 32'h3006_0050;  // STR  r6,[r0+0x50]
        imem[194] = 32'hF000_0000;  // HALT
        // Program 4 @0x380
        imem[224] = 32'h3001_0060;  // STR  r1,[r0+0x60]
        imem[225] = 32'hF000_0000;  // HALT

        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_pc",       64'(pc), 64'h0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_dmem_addr",64'(dmem_addr), 64'h0);
        check("rst_wdata",    64'(dmem_wdata), 64'h0);
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_halted",   64'(halted), 64'd0);
`ifdef CPU_V2_RETIRE_CNT_EN
        check("rst_retired",  64'(retired), 64'd0);
`endif
        reset = 1'b1;
        tick();

        // Program 1, with a start pulse mid-run that must be ignored
        do_start(32'h100);
        check("p1_fetch_addr", 64'(imem_addr), 64'h100);
        check("p1_busy", 64'(busy), 64'd1);
        tick();
        start_pc = 32'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_halt("p1_halt");
        check("p1_store_cnt", 64'(store_cnt), 64'd1);
        check("p1_st_addr", 64'(st_addr[0]), 64'h40);
        check("p1_st_data", 64'(st_data[0]), 64'd12);
        check("p1_pc", 64'(pc), 64'h110);
        check("p1_busy_end", 64'(busy), 64'd0);
`ifdef CPU_V2_RETIRE_CNT_EN
        check("p1_retired", 64'(retired), 64'd4);
`endif

        // Program 2: SUB wrap, negative immediate, NOP, r0 discard
        do_start(32'h200);
`ifdef CPU_V2_RETIRE_CNT_EN
        check("p2_retired_clr", 64'(retired), 64'd0);
`endif
        run_to_halt("p2_halt");
        check("p2_store_cnt", 64'(store_cnt), 64'd4);
        check("p2_sub_addr", 64'(st_addr[1]), 64'h44);
        check("p2_sub_data", 64'(st_data[1]), 64'hFFFF_FFFE);
        check("p2_addi_addr", 64'(st_addr[2]), 64'h48);
        check("p2_addi_data", 64'(st_data[2]), 64'hFFFF_FFFF);
        check("p2_r0_addr", 64'(st_addr[3]), 64'h0);
        check("p2_r0_data", 64'(st_data[3]), 64'h0);
        check("p2_pc", 64'(pc), 64'h21C);
`ifdef CPU_V2_RETIRE_CNT_EN
        check("p2_retired", 64'(retired), 64'd7);
`endif

        // Program 3: three wait cycles on every fetch
        imem_delay = 3;
        do_start(32'h300);
        for (int k = 0; k < 3; k++) begin
            check("p3_wait_req", 64'(imem_req), 64'd1);
            check("p3_wait_addr", 64'(imem_addr), 64'h300);
            check("p3_wait_ack", 64'(imem_ack), 64'd0);
            tick();
        end
        check("p3_ack", 64'(imem_ack), 64'd1);
        tick();
        tick();
        tick();
        check("p3_wb_req", 64'(imem_req), 64'd0);
        tick();
        check("p3_next_req", 64'(imem_req), 64'd1);
        check("p3_next_addr", 64'(imem_addr), 64'h304);
        run_to_halt("p3_halt");
        check("p3_store_cnt", 64'(store_cnt), 64'd5);
        check("p3_st_addr", 64'(st_addr[4]), 64'h50);
        check("p3_st_data", 64'(st_data[4]), 64'd12);
        imem_delay = 0;

        // Program 4: reset while a store is pending
        dmem_hold = 1'b1;
        do_start(32'h380);
        begin
            int n = 0;
            while (!dmem_req && n < 20) begin
                tick();
                n++;
            end
        end
        check("p4_req_seen", 64'(dmem_req), 64'd1);
        tick();
        tick();
        check("p4_req_held", 64'(dmem_req), 64'd1);
        check("p4_addr_held", 64'(dmem_addr), 64'h60);
        check("p4_data_held", 64'(dmem_wdata), 64'd5);
        reset = 1'b0;
        #1;
        check("p4_req_drop", 64'(dmem_req), 64'd0);
        check("p4_pc", 64'(pc), 64'h0);
        check("p4_busy", 64'(busy), 64'd0);
        check("p4_halted", 64'(halted), 64'd0);
        tick();
        check("p4_no_store", 64'(store_cnt), 64'd5);
        reset = 1'b1;
        dmem_hold = 1'b0;
        tick();

        // Resume after reset: registers were cleared, program 1 rebuilds them
        do_start(32'h100);
        run_to_halt("p5_halt");
        check("p5_store_cnt", 64'(store_cnt), 64'd6);
        check("p5_st_addr", 64'(st_addr[5]), 64'h40);
        check("p5_st_data", 64'(st_data[5]), 64'd12);
        check("p5_pc", 64'(pc), 64'h110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_v2.md
# cpu_v2

Parametrised multi-cycle successor to the first-generation ADD/ADDI core. It fetches 32-bit instructions over a req/ack instruction-memory port and executes ADD, ADDI, SUB and STR, plus HALT. Results are written to an internal register file, and stores go out over a req/ack data-memory port. It sits at the CPU top level between the instruction memory and data memory, with PC start and status visible for bring-up and test.

## Interface
- DATA_WIDTH, 32, register/ALU/data-memory word width (≥16)
- ADDR_WIDTH, 32, PC and memory address width
- REG_COUNT, 16, architectural registers; fixed at 16 by 4-bit register fields
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; one clock, no other clock domains
- start  input  1  pulse; in IDLE or HALTED, loads PC from start_pc and begins fetch
- start_pc  input  ADDR_WIDTH  initial PC, sampled with start
- imem_req  output  1  instruction fetch request
- imem_addr  output  ADDR_WIDTH  fetch address (= PC)
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word
- dmem_req  output  1  store request
- dmem_addr  output  ADDR_WIDTH  store address
- dmem_wdata  output  DATA_WIDTH  store data
- dmem_ack  input  1  store accepted
- pc  output  ADDR_WIDTH  current PC
- busy  output  1  high in any state except IDLE/HALTED
- halted  output  1  high in HALTED

## Operation
- Instruction fields: op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0], sign-extended to DATA_WIDTH.
- Opcodes:
  - 0x0 ADD: rd = rs1 + rs2
  - 0x1 ADDI: rd = rs1 + imm
  - 0x2 SUB: rd = rs1 − rs2
  - 0x3 STR: mem[rs1+imm] = rs2
  - 0xF HALT
  - All others: NOP.
- Arithmetic is modulo 2^DATA_WIDTH; the address sum is truncated to ADDR_WIDTH.
- r0 reads as 0; writes to r0 are discarded.
- States and transitions:
  - IDLE: start → FETCH.
  - FETCH: imem_req=1; on ack, latch the instruction → DECODE.
  - DECODE: read rs1/rs2 → EXECUTE.
  - EXECUTE: ALU/address compute. HALT → HALTED; STR → MEMORY; NOP → FETCH; else → WRITEBACK.
  - MEMORY: dmem_req=1; on dmem_ack → FETCH.
  - WRITEBACK: write rd → FETCH.
  - HALTED: start → FETCH at start_pc.
- PC increments by 4 when leaving EXECUTE, except HALT, where the PC stays on the HALT address. The PC wraps modulo 2^ADDR_WIDTH.
- Handshake rules:
  - req stays high, and addr/wdata stay stable, until ack is sampled high.
  - req drops in the cycle after ack.
  - ack while req is low is ignored.
- start outside IDLE/HALTED is ignored.
- Reset values: pc=0, registers=0, state=IDLE, imem_req=dmem_req=0, addresses/wdata=0, busy=halted=0.
- Reset during a pending handshake aborts it: req falls asynchronously, and no register or memory update occurs.

## Timing
- Zero-wait memory: ADD/ADDI/SUB take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
- STR takes 4 cycles (FETCH, DECODE, EXECUTE, MEMORY). NOP takes 3 cycles.
- Each wait cycle on imem_ack or dmem_ack adds 1 cycle.
- A register written in WRITEBACK is visible to the next instruction's DECODE; no hazards, since the core is strictly sequential.
- halted rises the cycle after HALT's EXECUTE.

## Configuration
- CPU_V2_RETIRE_CNT_EN defined:
  - Adds output retired (32 bits), reset to 0.
  - Increments by 1 on each WRITEBACK, MEMORY-ack and NOP completion; HALT not counted.
  - Wraps at 2^32 and clears on start.
- Undefined: no port and no counter logic.

## Structure
- Package cpu_v2_pkg holds:
  - opcode enum
  - FSM state enum
  - field bit-position constants
  - PC increment constant (4)
- Sub-module cpu_v2_regfile: parameterised DATA_WIDTH × 16 entries, 2 async read ports, 1 sync write port, r0 forced zero, async active-low reset clears all entries.

## Test plan
- Reset, start with start_pc=0x100, zero-wait memory; program ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; STR r3,[r0+0x40]; HALT → dmem write addr 0x40 data 12; halted=1, pc=0x110.
- SUB r4,r1,r2 with r1=5, r2=7 → r4=0xFFFFFFFE (wrap). ADDI r5,r0,0xFFFF → r5=0xFFFFFFFF.
- imem_ack delayed 3 cycles → imem_req and imem_addr held stable for 3 cycles; ADD completes in 7 cycles.
- ADDI r0,r0,9, then STR r0,[r0+0] → stored data 0.
- Assert reset while dmem_req=1 and ack is withheld → dmem_req drops immediately, no store, pc=0, busy=0. Then start resumes correctly.
- With CPU_V2_RETIRE_CNT_EN, run the first program → retired=4. Start again → retired clears to 0.
